// File: rtl/me_cpr_loader.sv
// -----------------------------------------------------------------------------
// me_cpr_loader
// Ping-pong buffer that collects current-picture rows for one macroblock and
// streams them, row by row, to the motion-estimation stage. One bank fills
// while the other bank is streamed out, so input can run ahead by one full
// macroblock.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid must keep its data stable until the
// transfer; ready never depends combinationally on the other side's valid or
// ready.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      upstream row valid
//   in_ready      a row can be accepted (write bank not full)
//   in_row        row of MACRO_DIM pixels, pixel 0 in the low PIX_W bits
//   out_valid     out_row holds a row for the ME stage
//   out_ready     ME stage accepts out_row
//   out_row       row being presented to the ME stage
//   out_row_idx   row number within the macroblock, 0 = top
//   out_last      high with out_valid on the bottom row
//   me_start      one-cycle pulse at the start of each streamed macroblock
//   mb_count      macroblocks fully streamed since reset (wraps)
// -----------------------------------------------------------------------------
module me_cpr_loader #(
    parameter int MACRO_DIM = 16,
    parameter int PIX_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MACRO_DIM*PIX_W-1:0]   in_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MACRO_DIM*PIX_W-1:0]   out_row,
    output logic [$clog2(MACRO_DIM)-1:0] out_row_idx,
    output logic                         out_last,
    output logic                         me_start,
    output logic [15:0]                  mb_count
);
    localparam int ROW_W = MACRO_DIM * PIX_W;
    localparam int IDX_W = $clog2(MACRO_DIM);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(MACRO_DIM - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    rd_state_t        state_q, state_d;
    logic [ROW_W-1:0] bank_mem [2][MACRO_DIM];
    logic [1:0]       full_q, full_d;
    logic             wr_sel, rd_sel;
    logic [IDX_W-1:0] wr_cnt, rd_cnt;
    logic             first_q;     // marks the first STREAM cycle of a macroblock
    logic             wr_fire, wr_done, rd_fire, rd_done, load_start;

    // Write side: the write bank is never the bank being streamed because a
    // bank stays full (and therefore not ready) until its last row leaves.
    assign in_ready = !rst && !full_q[wr_sel];
    assign wr_fire  = in_valid && in_ready;
    assign wr_done  = wr_fire && (wr_cnt == LAST_ROW);

    // Read FSM, next state and outputs
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        rd_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_sel]) begin
                    state_d    = STREAM;
                    load_start = 1'b1;
                end
            end
            STREAM: begin
                if (out_ready && (rd_cnt == LAST_ROW)) begin
                    state_d = IDLE;
                    rd_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid   = (state_q == STREAM);
    assign rd_fire     = out_valid && out_ready;
    assign me_start    = out_valid && first_q;
    assign out_last    = out_valid && (rd_cnt == LAST_ROW);
    assign out_row_idx = out_valid ? rd_cnt : '0;
    assign out_row     = out_valid ? bank_mem[rd_sel][rd_cnt] : '0;

    // A write completing on one bank and a read completing on the other can
    // land on the same edge; both updates apply.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_sel] = 1'b1;
        if (rd_done) full_d[rd_sel] = 1'b0;
    end

    // Row storage carries no reset: contents are only visible while streaming
    // a bank whose full flag was set after reset.
    always_ff @(posedge clk) begin
        if (wr_fire) bank_mem[wr_sel][wr_cnt] <= in_row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            first_q  <= 1'b0;
            full_q   <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            mb_count <= '0;
        end else begin
            state_q <= state_d;
            first_q <= load_start;
            full_q  <= full_d;

            if (wr_fire) begin
                if (wr_done) begin
                    wr_cnt <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            if (load_start) begin
                rd_cnt <= '0;
            end else if (rd_fire) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
            end

            if (rd_done) begin
                rd_sel   <= ~rd_sel;
                mb_count <= mb_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_me_cpr_loader.sv
// -----------------------------------------------------------------------------
// tb_me_cpr_loader
// Directed scenarios for the ping-pong macroblock loader. Inputs are driven
// and outputs sampled on the falling clock edge. Row data is generated from
// (macroblock, row, pixel) so every row is distinct and predictable.
// -----------------------------------------------------------------------------
module tb_me_cpr_loader;
    localparam int MD    = 16;
    localparam int PW    = 8;
    localparam int ROW_W = MD * PW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ROW_W-1:0] in_row = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ROW_W-1:0] out_row;
    logic [3:0]       out_row_idx;
    logic             out_last;
    logic             me_start;
    logic [15:0]      mb_count;

    int checks = 0;
    int errors = 0;
    int me_cnt = 0;

    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] obs_q[$];
    logic [3:0]       obs_idx[$];
    logic             obs_last[$];

    me_cpr_loader #(.MACRO_DIM(MD), .PIX_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .me_start    (me_start),
        .mb_count    (mb_count)
    );

    // clock
    always #5 clk = ~clk;

    // Row k of the stream: macroblock k/16, row k%16; pixel p = 16r + p + 7mb.
    function automatic logic [ROW_W-1:0] row_val(input int k);
        logic [ROW_W-1:0] v;
        int mb, r;
        mb = k / MD;
        r  = k % MD;
        for (int p = 0; p < MD; p++) v[p*PW +: PW] = 8'((16 * r + p + 7 * mb) & 255);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] junk_row();
        logic [ROW_W-1:0] v;
        for (int i = 0; i < ROW_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete(); obs_q.delete(); obs_idx.delete(); obs_last.delete();
        me_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer stream rows k0..k0+n-1; in_valid is high pct% of cycles.
    task automatic write_rows(input int k0, input int n, input int pct);
        int k, budget;
        logic v;
        k = k0;
        budget = 0;
        while (k < k0 + n && budget < 20000) begin
            @(negedge clk);
            v = ($urandom_range(1, 100) <= pct);
            in_valid = v;
            in_row = v ? row_val(k) : junk_row();
            if (v && in_ready) begin
                exp_q.push_back(row_val(k));
                k++;
            end
            budget++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_row = junk_row();
        checks++;
        if (k != k0 + n) begin
            errors++;
            $display("FAIL write_rows timeout: accepted %0d required %0d", k - k0, n);
        end
    endtask

    // Accept n rows from the DUT; out_ready is high pct% of cycles.
    task automatic collect_rows(input int n, input int pct);
        int got, budget;
        logic r;
        got = 0;
        budget = 0;
        while (got < n && budget < 40000) begin
            @(negedge clk);
            if (me_start) me_cnt++;
            r = ($urandom_range(1, 100) <= pct);
            out_ready = r;
            if (out_valid && r) begin
                obs_q.push_back(out_row);
                obs_idx.push_back(out_row_idx);
                obs_last.push_back(out_last);
                got++;
            end
            budget++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL collect_rows timeout: got %0d required %0d", got, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || me_start !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready %b out_valid %b me_start %b out_last %b required all 0",
                     in_ready, out_valid, me_start, out_last);
        end
        checks++;
        if (out_row !== '0 || out_row_idx !== 4'd0 || mb_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: out_row %h idx %0d mb_count %0d required 0", out_row, out_row_idx, mb_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready %b required 1", in_ready);
        end
    endtask

    task automatic test_single_mb();
        apply_reset();
        write_rows(0, 16, 100);
        checks++;
        if (out_valid !== 1'b0 || me_start !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_n: out_valid %b me_start %b required 0 0", out_valid, me_start);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || me_start !== 1'b1 || out_row !== row_val(0) || out_row_idx !== 4'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL single_first: valid %b start %b row %h idx %0d last %b required 1 1 %h 0 0",
                     out_valid, me_start, out_row, out_row_idx, out_last, row_val(0));
        end
        collect_rows(16, 100);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (me_cnt !== 0) begin
            errors++;
            $display("FAIL single_me_start_len: extra pulses %0d required 0", me_cnt);
        end
        checks++;
        if (mb_count !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: mb_count %0d out_valid %b required 1 0", mb_count, out_valid);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_count: rows %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_idx[i] !== 4'(i % MD) || obs_last[i] !== (i % MD == MD - 1)) begin
                errors++;
                $display("FAIL single_row %0d: got %h idx %0d last %b required %h idx %0d last %b",
                         i, obs_q[i], obs_idx[i], obs_last[i], exp_q[i], i % MD, (i % MD == MD - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        write_rows(0, 32, 100);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row_idx !== 4'd0) begin
            errors++;
            $display("FAIL b2b_full: in_ready %b out_valid %b idx %0d required 0 1 0", in_ready, out_valid, out_row_idx);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_row = row_val(32);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall cycle %0d: in_ready %b required 0", c, in_ready);
            end
        end
        in_valid = 1'b0;
        me_cnt = 0;
        fork
            write_rows(32, 16, 100);
            collect_rows(48, 100);
        join
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (mb_count !== 16'd3 || me_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_end: mb_count %0d me_start %0d required 3 2", mb_count, me_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: rows %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_idx[i] !== 4'(i % MD) || obs_last[i] !== (i % MD == MD - 1)) begin
                errors++;
                $display("FAIL b2b_row %0d: got %h idx %0d last %b required %h idx %0d",
                         i, obs_q[i], obs_idx[i], obs_last[i], exp_q[i], i % MD);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        fork
            write_rows(0, 1600, 50);
            collect_rows(1600, 50);
        join
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (mb_count !== 16'd100 || me_cnt !== 100) begin
            errors++;
            $display("FAIL rand_end: mb_count %0d me_start %0d required 100 100", mb_count, me_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: rows %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_idx[i] !== 4'(i % MD) || obs_last[i] !== (i % MD == MD - 1)) begin
                errors++;
                $display("FAIL rand_row %0d: got %h idx %0d last %b required %h idx %0d",
                         i, obs_q[i], obs_idx[i], obs_last[i], exp_q[i], i % MD);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        write_rows(0, 16, 100);
        collect_rows(7, 100);
        @(negedge clk);
        out_ready = 1'b0;
        me_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== row_val(7) || out_row_idx !== 4'd7 || me_start !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d: valid %b row %h idx %0d start %b required 1 %h 7 0",
                         c, out_valid, out_row, out_row_idx, me_start, row_val(7));
            end
            @(negedge clk);
        end
        collect_rows(9, 100);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (me_cnt !== 0 || mb_count !== 16'd1) begin
            errors++;
            $display("FAIL stall_end: me_start %0d mb_count %0d required 0 1", me_cnt, mb_count);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_idx[i] !== 4'(i)) begin
                errors++;
                $display("FAIL stall_row %0d: got %h idx %0d required %h idx %0d", i, obs_q[i], obs_idx[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        // reset during a partial load
        write_rows(0, 9, 100);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || mb_count !== 16'd0) begin
            errors++;
            $display("FAIL midload_rst: in_ready %b out_valid %b mb_count %0d required 0 0 0", in_ready, out_valid, mb_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); obs_idx.delete(); obs_last.delete();
        write_rows(16, 7, 100);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b0 || me_start !== 1'b0) begin
                errors++;
                $display("FAIL midload_partial cycle %0d: out_valid %b me_start %b required 0 0", c, out_valid, me_start);
            end
            @(negedge clk);
        end
        write_rows(23, 9, 100);
        me_cnt = 0;
        collect_rows(16, 100);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (me_cnt !== 1 || mb_count !== 16'd1) begin
            errors++;
            $display("FAIL midload_end: me_start %0d mb_count %0d required 1 1", me_cnt, mb_count);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_idx[i] !== 4'(i)) begin
                errors++;
                $display("FAIL midload_row %0d: got %h idx %0d required %h idx %0d", i, obs_q[i], obs_idx[i], exp_q[i], i);
            end
        end
        // reset during a stream
        write_rows(32, 16, 100);
        collect_rows(5, 100);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_row !== '0 || out_row_idx !== 4'd0 || me_start !== 1'b0 ||
            out_last !== 1'b0 || mb_count !== 16'd0) begin
            errors++;
            $display("FAIL midstream_rst: valid %b row %h idx %0d start %b last %b mb_count %0d required all 0",
                     out_valid, out_row, out_row_idx, me_start, out_last, mb_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); obs_idx.delete(); obs_last.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || me_start !== 1'b0) begin
                errors++;
                $display("FAIL midstream_idle cycle %0d: out_valid %b me_start %b required 0 0", c, out_valid, me_start);
            end
        end
        write_rows(48, 16, 100);
        me_cnt = 0;
        collect_rows(16, 100);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (me_cnt !== 1 || mb_count !== 16'd1) begin
            errors++;
            $display("FAIL midstream_end: me_start %0d mb_count %0d required 1 1", me_cnt, mb_count);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_idx[i] !== 4'(i)) begin
                errors++;
                $display("FAIL midstream_row %0d: got %h idx %0d required %h idx %0d", i, obs_q[i], obs_idx[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_mb_wrap();
        apply_reset();
        @(negedge clk);
        force dut.mb_count = 16'hFFFF;
        #1;
        release dut.mb_count;
        #1;
        checks++;
        if (mb_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: mb_count %h required ffff", mb_count);
        end
        write_rows(0, 16, 100);
        collect_rows(16, 100);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (mb_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: mb_count %h required 0000", mb_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_mb();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_random();
        test_mb_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
